// File: rtl/arb_pkg.sv
// Shared types and limits for the fetch/data memory port arbiter.
// Holds FSM state, owner encoding and parameter range limits.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;
    localparam int BURST_MIN   = 1;
    localparam int BURST_MAX   = 15;

    function automatic int clamp(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant choice between fetch and data plus the data-streak counter.
// Ports: clk, reset (sync active-low), arb (IDLE cycle), i_req/d_req
// (effective requests), grant_i/grant_d (one-hot, only when arb).
module mem_arb_grant
    import arb_pkg::*;
#(
    parameter int DATA_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);

    localparam int BURST = clamp(DATA_BURST, BURST_MIN, BURST_MAX);

    logic [3:0] d_streak;
    logic       hit;

    assign hit = (d_streak == 4'(BURST));

    // Data wins ties until it has taken BURST grants in a row
    // while a fetch was waiting.
    always_comb begin
        grant_d = arb & d_req & ~(i_req & hit);
        grant_i = arb & i_req & ~grant_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_streak <= 4'd0;
        end else if (arb && (i_req || d_req)) begin
            if (grant_i || !i_req) begin
                d_streak <= 4'd0;
            end else if (grant_d && !hit) begin
                d_streak <= d_streak + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and data.
// Ports: fetch i_* (req/addr/abort/ready/rdata/stall), data d_*
// (req/we/byteen/addr/wdata/ready/rdata/stall), memory mem_*.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_abort,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_byteen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int LAT = clamp(MEM_LAT, MEM_LAT_MIN, MEM_LAT_MAX);

    state_t      state;
    state_t      state_nx;
    owner_t      owner;
    logic [2:0]  lat_cnt;
    logic        aborted;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        arb;
    logic        i_go;
    logic        grant_i;
    logic        grant_d;
    logic        done;

    // A fetch that is being aborted in the same cycle is no request.
    assign i_go = i_req & ~i_abort;
    assign arb  = (state == ST_IDLE);
    assign done = (state == ST_WAIT) && (lat_cnt == 3'd0);

    mem_arb_grant #(
        .DATA_BURST (DATA_BURST)
    ) u_grant (
        .clk     (clk),
        .reset   (reset),
        .arb     (arb),
        .i_req   (i_go),
        .d_req   (d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (grant_i || grant_d) state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  if (done) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner   <= OWN_NONE;
            lat_cnt <= 3'd0;
            aborted <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    aborted <= 1'b0;
                    if (grant_d) begin
                        owner   <= OWN_D;
                        addr_q  <= d_addr;
                        we_q    <= d_we;
                        be_q    <= d_we ? d_byteen : 4'd0;
                        wdata_q <= d_we ? d_wdata : 32'd0;
                    end else if (grant_i) begin
                        owner   <= OWN_I;
                        addr_q  <= i_addr;
                        we_q    <= 1'b0;
                        be_q    <= 4'd0;
                        wdata_q <= 32'd0;
                    end
                end
                ST_ISSUE: begin
                    lat_cnt <= 3'(LAT - 1);
                    if (owner == OWN_I && i_abort) aborted <= 1'b1;
                end
                ST_WAIT: begin
                    if (owner == OWN_I && i_abort) aborted <= 1'b1;
                    if (done) begin
                        owner   <= OWN_NONE;
                        aborted <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: owner <= OWN_NONE;
            endcase
        end
    end

    assign mem_req    = (state == ST_ISSUE);
    assign mem_we     = mem_req & we_q;
    assign mem_byteen = be_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    // An abort arriving on the done cycle itself also kills the pulse.
    assign i_ready = done & (owner == OWN_I) & ~aborted & ~i_abort;
    assign d_ready = done & (owner == OWN_D);
    assign i_rdata = i_ready ? mem_rdata : 32'd0;
    assign d_rdata = (d_ready && !we_q) ? mem_rdata : 32'd0;
    assign i_stall = i_req & ~i_ready;
    assign d_stall = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2, DATA_BURST=4.
// Memory model returns addr ^ 32'hA5A50000 two cycles after mem_req.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_abort;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_byteen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic        p1v = 1'b0;
    logic        p2v = 1'b0;
    logic [31:0] p1a = 32'd0;
    logic [31:0] p2a = 32'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1v <= mem_req;
        p1a <= mem_addr;
        p2v <= p1v;
        p2a <= p1a;
    end

    assign mem_rdata = p2v ? (p2a ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

    mem_port_arbiter #(
        .MEM_LAT    (2),
        .DATA_BURST (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_abort    (i_abort),
        .i_ready    (i_ready),
        .i_rdata    (i_rdata),
        .i_stall    (i_stall),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_byteen   (d_byteen),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .d_stall    (d_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_byteen (mem_byteen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] pat;
        int         g;
        reset    = 1'b0;
        i_req    = 1'b0;
        i_addr   = 32'd0;
        i_abort  = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_byteen = 4'd0;
        d_addr   = 32'd0;
        d_wdata  = 32'd0;

        // reset state
        cyc();
        cyc();
        #1;
        chk("rst_mreq", 32'(mem_req), 32'd0);
        chk("rst_iready", 32'(i_ready), 32'd0);
        chk("rst_dready", 32'(d_ready), 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mbe", 32'(mem_byteen), 32'd0);
        reset = 1'b1;
        cyc();

        // 1: fetch only
        cyc();
        i_req  = 1'b1;
        i_addr = 32'h3000;
        #1;
        chk("t1_stall0", 32'(i_stall), 32'd1);
        chk("t1_mreq0", 32'(mem_req), 32'd0);
        cyc();
        #1;
        chk("t1_mreq1", 32'(mem_req), 32'd1);
        chk("t1_maddr", mem_addr, 32'h3000);
        chk("t1_mwe", 32'(mem_we), 32'd0);
        chk("t1_stall1", 32'(i_stall), 32'd1);
        cyc();
        #1;
        chk("t1_mreq2", 32'(mem_req), 32'd0);
        chk("t1_rdy2", 32'(i_ready), 32'd0);
        chk("t1_stall2", 32'(i_stall), 32'd1);
        cyc();
        #1;
        chk("t1_rdy3", 32'(i_ready), 32'd1);
        chk("t1_rdata", i_rdata, 32'hA5A5_3000);
        chk("t1_stall3", 32'(i_stall), 32'd0);
        cyc();
        i_req = 1'b0;
        #1;
        chk("t1_rdy4", 32'(i_ready), 32'd0);
        chk("t1_rdata4", i_rdata, 32'd0);

        // 2: fetch and load together, data first
        cyc();
        i_req  = 1'b1;
        i_addr = 32'h4000;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h10;
        cyc();
        #1;
        chk("t2_mreq1", 32'(mem_req), 32'd1);
        chk("t2_maddr1", mem_addr, 32'h10);
        cyc();
        cyc();
        #1;
        chk("t2_drdy3", 32'(d_ready), 32'd1);
        chk("t2_drdata", d_rdata, 32'hA5A5_0010);
        chk("t2_irdy3", 32'(i_ready), 32'd0);
        cyc();
        d_req = 1'b0;
        #1;
        chk("t2_mreq4", 32'(mem_req), 32'd0);
        cyc();
        #1;
        chk("t2_mreq5", 32'(mem_req), 32'd1);
        chk("t2_maddr5", mem_addr, 32'h4000);
        cyc();
        #1;
        chk("t2_irdy6", 32'(i_ready), 32'd0);
        cyc();
        #1;
        chk("t2_irdy7", 32'(i_ready), 32'd1);
        chk("t2_irdata", i_rdata, 32'hA5A5_4000);
        cyc();
        i_req = 1'b0;

        // 3: data burst limit (1 = data store, 0 = fetch)
        cyc();
        pat      = 10'b1111011110;
        g        = 0;
        i_req    = 1'b1;
        i_addr   = 32'h5000;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_byteen = 4'hF;
        d_addr   = 32'h100;
        d_wdata  = 32'h1;
        for (int c = 0; c < 60; c++) begin
            cyc();
            #1;
            if (mem_req && g < 10) begin
                chk($sformatf("t3_we%0d", g),
                    32'(mem_we), 32'(pat[9-g]));
                g++;
            end
            if (d_ready) begin
                d_addr  = d_addr + 32'd4;
                d_wdata = d_wdata + 32'd1;
            end
            if (i_ready && g == 10) break;
        end
        chk("t3_grants", 32'(g), 32'd10);
        cyc();
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;

        // 4: store
        cyc();
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_byteen = 4'b0011;
        d_addr   = 32'h20;
        d_wdata  = 32'hAABB_CCDD;
        cyc();
        #1;
        chk("t4_mreq", 32'(mem_req), 32'd1);
        chk("t4_mwe", 32'(mem_we), 32'd1);
        chk("t4_mbe", 32'(mem_byteen), 32'h3);
        chk("t4_mwd", mem_wdata, 32'hAABB_CCDD);
        chk("t4_maddr", mem_addr, 32'h20);
        cyc();
        #1;
        chk("t4_mwe2", 32'(mem_we), 32'd0);
        chk("t4_drdy2", 32'(d_ready), 32'd0);
        cyc();
        #1;
        chk("t4_drdy3", 32'(d_ready), 32'd1);
        chk("t4_drdata", d_rdata, 32'd0);
        cyc();
        d_req = 1'b0;
        d_we  = 1'b0;

        // 5: abort during WAIT
        cyc();
        i_req  = 1'b1;
        i_addr = 32'h6000;
        cyc();
        #1;
        chk("t5_mreq1", 32'(mem_req), 32'd1);
        cyc();
        i_abort = 1'b1;
        cyc();
        i_abort = 1'b0;
        i_req   = 1'b0;
        #1;
        chk("t5_irdy3", 32'(i_ready), 32'd0);
        chk("t5_rdata3", i_rdata, 32'd0);
        cyc();
        i_req  = 1'b1;
        i_addr = 32'h7000;
        #1;
        chk("t5_mreq4", 32'(mem_req), 32'd0);
        chk("t5_irdy4", 32'(i_ready), 32'd0);
        cyc();
        #1;
        chk("t5_mreq5", 32'(mem_req), 32'd1);
        chk("t5_maddr5", mem_addr, 32'h7000);
        cyc();
        cyc();
        #1;
        chk("t5_irdy7", 32'(i_ready), 32'd1);
        chk("t5_rdata7", i_rdata, 32'hA5A5_7000);
        cyc();
        i_req = 1'b0;

        // 6: reset during WAIT
        cyc();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h30;
        cyc();
        #1;
        chk("t6_mreq1", 32'(mem_req), 32'd1);
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        #1;
        chk("t6_drdy3", 32'(d_ready), 32'd0);
        chk("t6_mreq3", 32'(mem_req), 32'd0);
        chk("t6_maddr3", mem_addr, 32'd0);
        chk("t6_drdata3", d_rdata, 32'd0);
        cyc();
        #1;
        chk("t6_mreq4", 32'(mem_req), 32'd1);
        chk("t6_maddr4", mem_addr, 32'h30);
        cyc();
        #1;
        chk("t6_drdy5", 32'(d_ready), 32'd0);
        cyc();
        #1;
        chk("t6_drdy6", 32'(d_ready), 32'd1);
        chk("t6_drdata6", d_rdata, 32'hA5A5_0030);
        cyc();
        d_req = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
